// File: rtl/mod_cipher_stream_pkg.sv
// Shared types and default constants for the streaming modular cipher engine.
// Package name: cipher_pkg.
package cipher_pkg;

  typedef enum logic [1:0] {
    MODE_ENC = 2'b01,
    MODE_DEC = 2'b10
  } cipher_mode_e;

  localparam int         DATA_W_DEF  = 8;
  localparam int         MODULUS_DEF = 227;
  localparam logic [7:0] CHAR_LO_DEF = 8'h61;
  localparam logic [7:0] CHAR_HI_DEF = 8'h7A;
  localparam logic [7:0] NULL_CHAR   = 8'h00;

  // One buffered result at the default width: error flag above the data word.
  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/mod_cipher_stream_if.sv
// Key, input-stream and output-stream signals of the cipher engine.
// master = the side that produces words and consumes results; slave = the engine.
interface mod_cipher_stream_if #(parameter int DATA_W = 8);
  logic              key_load;
  logic [DATA_W-1:0] key_in;
  logic              key_err;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [15:0]       err_count;

  modport master (
    output key_load, key_in, in_valid, in_mode, in_data, out_ready,
    input  key_err, in_ready, out_valid, out_data, out_err, err_count
  );

  modport slave (
    input  key_load, key_in, in_valid, in_mode, in_data, out_ready,
    output key_err, in_ready, out_valid, out_data, out_err, err_count
  );
endinterface

// File: rtl/mod_cipher_stream_fifo.sv
// Synchronous output buffer for the cipher engine. Pointers wrap naturally
// because DEPTH is a power of two; push and pop together leave count unchanged.
module cipher_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/mod_cipher_stream.sv
// Streaming modular-subtraction cipher: enc C=(P-K) mod M, dec P=(C+K) mod M.
// One capture stage, then a result FIFO; errored words travel in order as NULL_CHAR.
// Optional feature macro: CIPHER_ERR_CNT_EN builds the saturating error counter;
// without it err_count is tied to zero.
module mod_cipher_stream
  import cipher_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              MODULUS    = 227,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CHAR_LO  = DATA_W'(CHAR_LO_DEF),
  parameter logic [DATA_W-1:0] CHAR_HI  = DATA_W'(CHAR_HI_DEF)
) (
  input logic                clk,
  input logic                rst,
  mod_cipher_stream_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W:0] MOD_W   = (DATA_W+1)'(MODULUS);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // Operands are both < M, so one conditional correction is enough. When
  // M == 2**DATA_W, MOD_W reads as negative once signed, but the low DATA_W
  // bits of the corrected sum are still the right residue.
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] p,
                                                input logic [DATA_W-1:0] k);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, k});
    if (d < 0) d = d + $signed(MOD_W);
    return d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] c,
                                                input logic [DATA_W-1:0] k);
    logic [DATA_W:0] s;
    s = {1'b0, c} + {1'b0, k};
    if (s >= MOD_W) s = s - MOD_W;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              key_valid_q, key_valid_d;
  logic              key_err_q, key_err_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [DATA_W-1:0] key_p1_q, key_p1_d;
  logic [1:0]        mode_p1_q, mode_p1_d;
  logic              err_p1_q, err_p1_d;
  logic              accept, in_err;
  logic [DATA_W-1:0] res_p1;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic [CW-1:0]     fifo_count;

  // Ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready = !rst &&
    (({1'b0, fifo_count} + {{CW{1'b0}}, vld_p1_q}) < DEPTH_W);
  assign accept    = bus.in_valid && bus.in_ready;
  assign fifo_pop  = bus.out_valid && bus.out_ready;
  assign fifo_push = vld_p1_q && (!fifo_full || fifo_pop);
  assign bus.key_err   = key_err_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_rdata[DATA_W-1:0];
  assign bus.out_err   = fifo_rdata[DATA_W];

  // Validate the incoming word against the key state that exists before this edge.
  always_comb begin
    in_err = !key_valid_q;
    case (bus.in_mode)
      MODE_ENC: if (bus.in_data < CHAR_LO || bus.in_data > CHAR_HI) in_err = 1'b1;
      MODE_DEC: if ({1'b0, bus.in_data} >= MOD_W) in_err = 1'b1;
      default:  in_err = 1'b1;
    endcase
  end

  // Key register update and stage-1 capture values.
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    if (bus.key_load) begin
      if ({1'b0, bus.key_in} < MOD_W) begin
        key_d       = bus.key_in;
        key_valid_d = 1'b1;
        key_err_d   = 1'b0;
      end else begin
        key_err_d   = 1'b1;
      end
    end
    vld_p1_d  = accept;
    data_p1_d = accept ? bus.in_data : data_p1_q;
    key_p1_d  = accept ? key_q       : key_p1_q;
    mode_p1_d = accept ? bus.in_mode : mode_p1_q;
    err_p1_d  = accept ? in_err      : err_p1_q;
  end

  // Control flops: key state and stage-1 valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      vld_p1_q    <= vld_p1_d;
    end
  end

  // ---- stage 1: captured word, arithmetic feeds the FIFO write ----
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
    key_p1_q  <= key_p1_d;
    mode_p1_q <= mode_p1_d;
    err_p1_q  <= err_p1_d;
  end

  // Modular result, or NULL_CHAR for an errored word.
  always_comb begin
    res_p1 = DATA_W'(NULL_CHAR);
    if (!err_p1_q)
      res_p1 = (mode_p1_q == MODE_ENC) ? mod_sub(data_p1_q, key_p1_q)
                                       : mod_add(data_p1_q, key_p1_q);
  end

  // ---- FIFO: result buffer toward the consumer ----
  cipher_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({err_p1_q, res_p1}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CIPHER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count errored words as they leave the engine.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fifo_pop && bus.out_err) err_cnt_d = sat_inc(err_cnt_q);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_mod_cipher_stream.sv
// Directed bench for mod_cipher_stream (M=227, DATA_W=8, FIFO_DEPTH=4).
// A queue-based reference model predicts every output word from modular
// arithmetic on integers; a negedge process compares it each cycle.
module tb_mod_cipher_stream;
  import cipher_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_cipher_stream_if #(.DATA_W(8)) bus ();

  mod_cipher_stream #(
    .DATA_W(8), .MODULUS(227), .FIFO_DEPTH(4), .CHAR_LO(8'h61), .CHAR_HI(8'h7A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    fifo_entry_t e;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   m_key = 0;
  bit   m_kv = 1'b0;
  int   m_errcnt = 0;
  int   cyc = 0;

  function automatic fifo_entry_t model(input logic [1:0] mode, input int d, input int k, input bit kv);
    fifo_entry_t e;
    e.err  = 1'b1;
    e.data = 8'h00;
    if (!kv) return e;
    if (mode == 2'b01) begin
      if (d < 'h61 || d > 'h7A) return e;
      e.data = 8'((((d - k) % 227) + 227) % 227);
    end else if (mode == 2'b10) begin
      if (d >= 227) return e;
      e.data = 8'((d + k) % 227);
    end else begin
      return e;
    end
    e.err = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_key = 0;
      m_kv = 1'b0;
      m_errcnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
`ifdef CIPHER_ERR_CNT_EN
        if (exp_q[0].e.err && m_errcnt < 65535) m_errcnt++;
`endif
        void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t x;
        x.e   = model(bus.in_mode, int'(bus.in_data), m_key, m_kv);
        x.cyc = cyc;
        exp_q.push_back(x);
      end
      if (bus.key_load && int'(bus.key_in) < 227) begin
        m_key = int'(bus.key_in);
        m_kv  = 1'b1;
      end
    end
  end

  // Per-cycle comparison: visibility (2-cycle latency), data, error flag, counter.
  always @(negedge clk) begin
    if (!rst) begin
      logic vis;
      vis = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 1);
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, vis});
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0].e.data});
        chk("out_err", {31'd0, bus.out_err}, {31'd0, exp_q[0].e.err});
      end
      chk("err_count", {16'd0, bus.err_count}, m_errcnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [7:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(posedge clk);
    #1 bus.key_load = 1'b0;
  endtask

  task automatic send(input logic [1:0] mode, input logic [7:0] d);
    bit ok = 1'b0;
    bus.in_mode  = mode;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic get_out(input string name, input logic [7:0] ed, input logic ee);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_data"}, {24'd0, bus.out_data}, {24'd0, ed});
      chk({name, "_err"}, {31'd0, bus.out_err}, {31'd0, ee});
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.key_load = 1'b0; bus.key_in = '0;
    bus.in_valid = 1'b0; bus.in_mode = 2'b00; bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_key_err", {31'd0, bus.key_err}, 0);
    chk("rst_err_count", {16'd0, bus.err_count}, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, bus.in_ready}, 1);

    // 1: key 50, enc 'a' -> 47, two-cycle latency
    load_key(8'd50);
    send(2'b01, 8'd97);
    @(negedge clk);
    chk("t1_early_valid", {31'd0, bus.out_valid}, 0);
    @(negedge clk);
    chk("t1_valid", {31'd0, bus.out_valid}, 1);
    chk("t1_data", {24'd0, bus.out_data}, 47);
    chk("t1_err", {31'd0, bus.out_err}, 0);

    // 2: key 200, wrap in both directions
    @(posedge clk); #1;
    load_key(8'd200);
    send(2'b01, 8'd98);
    get_out("t2_enc", 8'd125, 1'b0);
    @(posedge clk); #1;
    send(2'b10, 8'd125);
    get_out("t2_dec", 8'd98, 1'b0);

    // 3: out-of-range char and illegal mode, in order
    @(posedge clk); #1;
    send(2'b01, 8'h41);
    send(2'b11, 8'd97);
    get_out("t3_badchar", 8'd0, 1'b1);
    get_out("t3_badmode", 8'd0, 1'b1);
    repeat (3) @(negedge clk);
`ifdef CIPHER_ERR_CNT_EN
    chk("t3_err_count", {16'd0, bus.err_count}, 2);
`else
    chk("t3_err_count", {16'd0, bus.err_count}, 0);
`endif

    // 4: rejected key keeps 200; no key after reset -> error
    @(posedge clk); #1;
    load_key(8'd230);
    @(negedge clk);
    chk("t4_key_err", {31'd0, bus.key_err}, 1);
    @(posedge clk); #1;
    send(2'b01, 8'd97);
    get_out("t4_oldkey", 8'd124, 1'b0);
    @(posedge clk); #1;
    pulse_reset();
    send(2'b01, 8'd97);
    get_out("t4_nokey", 8'd0, 1'b1);

    // 5: backpressure, 6 words, no loss
    @(posedge clk); #1;
    load_key(8'd10);
    chk("t5_key_err_clr", {31'd0, bus.key_err}, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b01, 8'(99 + i));
    chk("t5_full_in_ready", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    chk("t5_still_blocked", {31'd0, bus.in_ready}, 0);
    chk("t5_head_data", {24'd0, bus.out_data}, 89);
    fork
      begin
        send(2'b01, 8'd103);
        send(2'b10, 8'd220);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (12) @(negedge clk);
    chk("t5_drained", {31'd0, bus.out_valid}, 0);

    // 6: reset with words buffered discards them
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(2'b01, 8'd120);
    send(2'b11, 8'd120);
    send(2'b10, 8'd5);
    repeat (3) @(posedge clk);
    #1 chk("t6_buffered", {31'd0, bus.out_valid}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_flush_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_stale", {31'd0, bus.out_valid}, 0);
    chk("t6_err_count", {16'd0, bus.err_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
